// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. It walks a program counter, issues one read at
// a time to instruction memory using a req/ack handshake, and parks the
// returned word in a single-entry instruction register until the consumer
// takes it. A branch redirect flushes the instruction register. If a read is
// already outstanding when the branch arrives, that read is allowed to finish
// and its data is thrown away.
//
// Parameters
//   ADDR_W          program counter / memory address width
//   INSN_W          instruction word width
//   RESET_PC        pc value loaded on reset
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous, active-high reset
//   enable_i        allow new memory requests to start
//   branch_valid_i  single-cycle redirect request
//   branch_target_i redirect address
//   mem_req_o       read request, held until mem_ack_i
//   mem_addr_o      read address, stable while mem_req_o is high
//   mem_ack_i       one-cycle completion strobe
//   mem_rdata_i     read data, valid with mem_ack_i
//   pc_o            address of the next instruction to fetch
//   ir_o            instruction register
//   ir_pc_o         address that ir_o was fetched from
//   ir_valid_o      ir_o holds an unconsumed instruction
//   ir_ready_i      consumer accepts ir_o when ir_valid_o is also high
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSN_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              branch_valid_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INSN_W-1:0] mem_rdata_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INSN_W-1:0] ir_o,
  output logic [ADDR_W-1:0] ir_pc_o,
  output logic              ir_valid_o,
  input  logic              ir_ready_i
);

  localparam logic [ADDR_W-1:0] PcOne = ADDR_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDrain
  } state_e;

  state_e              state_q,    state_d;
  logic [ADDR_W-1:0]   pc_q,       pc_d;
  logic                mem_req_q,  mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [INSN_W-1:0]   ir_q,       ir_d;
  logic [ADDR_W-1:0]   ir_pc_q,    ir_pc_d;
  logic                ir_valid_q, ir_valid_d;

  // Next-state logic. mem_req/mem_addr are computed here and registered, so a
  // request appears the cycle after the decision to start it.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;

    unique case (state_q)
      StIdle: begin
        if (branch_valid_i) begin
          pc_d       = branch_target_i;
          ir_valid_d = 1'b0;
        end else if (enable_i) begin
          state_d    = StFetch;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
      end

      StFetch: begin
        if (branch_valid_i) begin
          pc_d       = branch_target_i;
          ir_valid_d = 1'b0;
          if (mem_ack_i) begin
            // Response arrives together with the redirect: drop it.
            state_d   = StIdle;
            mem_req_d = 1'b0;
          end else begin
            // Request must still complete; keep req/addr as they are.
            state_d = StDrain;
          end
        end else if (mem_ack_i) begin
          ir_d       = mem_rdata_i;
          ir_pc_d    = mem_addr_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + PcOne;
          mem_req_d  = 1'b0;
          state_d    = StHold;
        end
      end

      StHold: begin
        // A branch wins over ir_ready: the flushed word is not consumed.
        if (branch_valid_i) begin
          pc_d       = branch_target_i;
          ir_valid_d = 1'b0;
          state_d    = StIdle;
        end else if (ir_valid_q && ir_ready_i) begin
          ir_valid_d = 1'b0;
          if (enable_i) begin
            state_d    = StFetch;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StDrain: begin
        // Latest redirect wins; the stale response never touches pc or ir.
        if (branch_valid_i) begin
          pc_d = branch_target_i;
        end
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end
      end

      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign pc_o       = pc_q;
  assign ir_o       = ir_q;
  assign ir_pc_o    = ir_pc_q;
  assign ir_valid_o = ir_valid_q;

`ifndef SYNTHESIS
  // An unacknowledged request stays up with an unchanged address.
  req_held_a : assert property (@(posedge clk) disable iff (reset)
    (mem_req_q && !mem_ack_i) |=> (mem_req_q && $stable(mem_addr_q)));

  // A valid instruction only ever sits in the HOLD state.
  valid_in_hold_a : assert property (@(posedge clk) disable iff (reset)
    ir_valid_q |-> (state_q == StHold));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns / 1ps
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       branch_valid;
  logic [7:0] branch_target;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [7:0] ir_pc;
  logic       ir_valid;
  logic       ir_ready;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .ADDR_W  (8),
    .INSN_W  (8),
    .RESET_PC(8'h00)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable_i       (enable),
    .branch_valid_i (branch_valid),
    .branch_target_i(branch_target),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .mem_ack_i      (mem_ack),
    .mem_rdata_i    (mem_rdata),
    .pc_o           (pc),
    .ir_o           (ir),
    .ir_pc_o        (ir_pc),
    .ir_valid_o     (ir_valid),
    .ir_ready_i     (ir_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_a;

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 8'h00;
    mem_ack       = 1'b0;
    mem_rdata     = 8'h00;
    ir_ready      = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_mem_req",  32'(mem_req),  32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h00);
    check_eq("rst_pc",       32'(pc),       32'h00);
    check_eq("rst_ir",       32'(ir),       32'h00);
    check_eq("rst_ir_pc",    32'(ir_pc),    32'h00);
    check_eq("rst_ir_valid", 32'(ir_valid), 32'd0);

    // First fetch: request to 0x00, ack after 2 cycles with 0xA5
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    check_eq("f0_mem_req",  32'(mem_req),  32'd1);
    check_eq("f0_mem_addr", 32'(mem_addr), 32'h00);
    tick();
    check_eq("f0_req_held", 32'(mem_req),  32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 8'hA5;
    tick();
    mem_ack = 1'b0;
    check_eq("f0_ir",       32'(ir),       32'hA5);
    check_eq("f0_ir_pc",    32'(ir_pc),    32'h00);
    check_eq("f0_ir_valid", 32'(ir_valid), 32'd1);
    check_eq("f0_pc",       32'(pc),       32'h01);
    check_eq("f0_req_drop", 32'(mem_req),  32'd0);

    // Consumer stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_mem_req",  32'(mem_req),  32'd0);
      check_eq("stall_ir",       32'(ir),       32'hA5);
      check_eq("stall_pc",       32'(pc),       32'h01);
      check_eq("stall_ir_valid", 32'(ir_valid), 32'd1);
    end

    // Consume: next request goes to 0x01
    ir_ready = 1'b1;
    tick();
    check_eq("take_mem_req",  32'(mem_req),  32'd1);
    check_eq("take_mem_addr", 32'(mem_addr), 32'h01);
    check_eq("take_ir_valid", 32'(ir_valid), 32'd0);

    // Sequential stream 0x01..0xFF, 0x00, 0x01 with immediate acks
    exp_a = 8'h01;
    for (int i = 0; i < 257; i++) begin
      mem_ack   = 1'b1;
      mem_rdata = exp_a ^ 8'h5A;
      tick();
      mem_ack = 1'b0;
      check_eq("seq_ir_pc", 32'(ir_pc), 32'(exp_a));
      check_eq("seq_ir",    32'(ir),    32'(exp_a ^ 8'h5A));
      tick();
      exp_a = exp_a + 8'h01;
    end
    ir_ready = 1'b0;
    check_eq("seq_end_addr", 32'(mem_addr), 32'h02);
    check_eq("seq_end_pc",   32'(pc),       32'h02);

    // Fetch 0x02, then start fetch at 0x03
    mem_ack   = 1'b1;
    mem_rdata = 8'h3C;
    tick();
    mem_ack  = 1'b0;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check_eq("b40_pre_addr", 32'(mem_addr), 32'h03);

    // Branch to 0x40 mid-request, ack 3 cycles later is discarded
    branch_valid  = 1'b1;
    branch_target = 8'h40;
    tick();
    branch_valid = 1'b0;
    check_eq("b40_req",      32'(mem_req),  32'd1);
    check_eq("b40_addr",     32'(mem_addr), 32'h03);
    check_eq("b40_pc",       32'(pc),       32'h40);
    check_eq("b40_ir_valid", 32'(ir_valid), 32'd0);
    tick();
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    check_eq("b40_drain_req",   32'(mem_req),  32'd0);
    check_eq("b40_drain_valid", 32'(ir_valid), 32'd0);
    check_eq("b40_drain_ir",    32'(ir),       32'h3C);
    check_eq("b40_drain_pc",    32'(pc),       32'h40);
    tick();
    check_eq("b40_next_req",  32'(mem_req),  32'd1);
    check_eq("b40_next_addr", 32'(mem_addr), 32'h40);

    // Branch to 0x80 in the same cycle as mem_ack
    mem_ack       = 1'b1;
    mem_rdata     = 8'h77;
    branch_valid  = 1'b1;
    branch_target = 8'h80;
    tick();
    mem_ack      = 1'b0;
    branch_valid = 1'b0;
    check_eq("b80_req",      32'(mem_req),  32'd0);
    check_eq("b80_ir_valid", 32'(ir_valid), 32'd0);
    check_eq("b80_ir",       32'(ir),       32'h3C);
    check_eq("b80_pc",       32'(pc),       32'h80);
    tick();
    check_eq("b80_next_req",   32'(mem_req),  32'd1);
    check_eq("b80_next_addr",  32'(mem_addr), 32'h80);
    check_eq("b80_next_valid", 32'(ir_valid), 32'd0);

    // Two branches while draining: latest target wins
    branch_valid  = 1'b1;
    branch_target = 8'h10;
    tick();
    branch_target = 8'h20;
    tick();
    branch_valid = 1'b0;
    check_eq("dd_pc",   32'(pc),       32'h20);
    check_eq("dd_addr", 32'(mem_addr), 32'h80);
    check_eq("dd_req",  32'(mem_req),  32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 8'h99;
    tick();
    mem_ack = 1'b0;
    check_eq("dd_done_req", 32'(mem_req), 32'd0);
    check_eq("dd_done_pc",  32'(pc),      32'h20);
    check_eq("dd_done_ir",  32'(ir),      32'h3C);
    tick();
    check_eq("dd_next_addr", 32'(mem_addr), 32'h20);

    // Branch beats ir_ready in HOLD
    mem_ack   = 1'b1;
    mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0;
    check_eq("pri_ir_valid", 32'(ir_valid), 32'd1);
    check_eq("pri_ir",       32'(ir),       32'h5A);
    check_eq("pri_ir_pc",    32'(ir_pc),    32'h20);
    check_eq("pri_pc",       32'(pc),       32'h21);
    ir_ready      = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 8'h30;
    tick();
    ir_ready     = 1'b0;
    branch_valid = 1'b0;
    check_eq("pri_flush_valid", 32'(ir_valid), 32'd0);
    check_eq("pri_flush_pc",    32'(pc),       32'h30);
    check_eq("pri_flush_req",   32'(mem_req),  32'd0);
    tick();
    check_eq("pri_next_addr", 32'(mem_addr), 32'h30);

    // enable low: outstanding request completes, nothing new starts
    enable    = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'h11;
    tick();
    mem_ack = 1'b0;
    check_eq("en_ir",    32'(ir),    32'h11);
    check_eq("en_ir_pc", 32'(ir_pc), 32'h30);
    check_eq("en_pc",    32'(pc),    32'h31);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check_eq("en_idle_valid", 32'(ir_valid), 32'd0);
    check_eq("en_idle_req",   32'(mem_req),  32'd0);

    // Stray ack in IDLE is ignored
    mem_ack   = 1'b1;
    mem_rdata = 8'hFF;
    tick();
    mem_ack = 1'b0;
    check_eq("stray_ir",    32'(ir),       32'h11);
    check_eq("stray_valid", 32'(ir_valid), 32'd0);
    check_eq("stray_pc",    32'(pc),       32'h31);
    check_eq("stray_req",   32'(mem_req),  32'd0);
    tick();
    check_eq("en_low_req", 32'(mem_req), 32'd0);

    // Reset pulsed mid-request
    enable = 1'b1;
    tick();
    check_eq("mr_req",  32'(mem_req),  32'd1);
    check_eq("mr_addr", 32'(mem_addr), 32'h31);
    reset = 1'b1;
    #2;
    check_eq("mr_async_req",  32'(mem_req),  32'd0);
    check_eq("mr_async_addr", 32'(mem_addr), 32'h00);
    check_eq("mr_async_pc",   32'(pc),       32'h00);
    tick();
    reset = 1'b0;
    tick();
    check_eq("mr_next_req",   32'(mem_req),  32'd1);
    check_eq("mr_next_addr",  32'(mem_addr), 32'h00);
    check_eq("mr_next_valid", 32'(ir_valid), 32'd0);
    check_eq("mr_next_ir",    32'(ir),       32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, width of program counter and memory address.
REQ-002 Parameter INSN_W, default 8, width of instruction word and instruction register.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset (ADDR_W bits).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  when low, no new memory request is started; an outstanding request completes normally.
REQ-007 branch_valid  input  1  single-cycle redirect request.
REQ-008 branch_target  input  ADDR_W  redirect address, sampled when branch_valid=1.
REQ-009 mem_req  output  1  memory read request, held high until mem_ack.
REQ-010 mem_addr  output  ADDR_W  read address, stable while mem_req=1.
REQ-011 mem_ack  input  1  one-cycle completion strobe; mem_rdata is valid in the same cycle.
REQ-012 mem_rdata  input  INSN_W  instruction word returned by memory.
REQ-013 pc  output  ADDR_W  address of the next instruction to fetch.
REQ-014 ir  output  INSN_W  instruction register.
REQ-015 ir_pc  output  ADDR_W  address the instruction in ir was fetched from.
REQ-016 ir_valid  output  1  ir holds an unconsumed instruction.
REQ-017 ir_ready  input  1  consumer accepts ir in a cycle where ir_valid=1 and ir_ready=1.

Function
REQ-018 FSM states: IDLE (no request), FETCH (request outstanding), HOLD (ir full, waiting for consumer), DRAIN (request outstanding, response to be discarded).
REQ-019 IDLE: mem_req=0; if enable=1 and no branch this cycle -> FETCH, with mem_addr=pc latched.
REQ-020 FETCH: mem_req=1, mem_addr=latched address; on mem_ack: ir<=mem_rdata, ir_pc<=mem_addr, ir_valid<=1, pc<=pc+1 -> HOLD.
REQ-021 pc increment wraps modulo 2^ADDR_W (all-ones + 1 = 0); no overflow flag.
REQ-022 HOLD: mem_req=0; on ir_valid&&ir_ready: ir_valid<=0 -> FETCH if enable=1, else IDLE; ir/ir_pc retain their last values.
REQ-023 Fetch latency: mem_req asserted the cycle after entering FETCH from reset/IDLE; ir_valid rises the cycle after mem_ack.
REQ-024 Branch in IDLE or HOLD: pc<=branch_target, ir_valid<=0 (flush) -> IDLE.
REQ-025 Branch in FETCH without mem_ack same cycle: pc<=branch_target, ir_valid<=0 -> DRAIN; mem_req and mem_addr unchanged.
REQ-026 Branch in FETCH with mem_ack same cycle: response discarded, pc<=branch_target, ir_valid<=0 -> IDLE.
REQ-027 DRAIN: mem_req=1 with old address; on mem_ack discard mem_rdata, ir/ir_valid unchanged -> IDLE; pc untouched by the drain.
REQ-028 Branch in DRAIN: pc<=branch_target (latest wins), remain in DRAIN until mem_ack.
REQ-029 Branch has priority over ir_ready in the same cycle; flushed instruction counts as not consumed.
REQ-030 mem_ack outside FETCH/DRAIN is ignored.

Reset
REQ-031 reset=1 asynchronously forces: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, ir=0, ir_pc=0, ir_valid=0.
REQ-032 Reset asserted mid-request abandons the request; first request after deassertion is to RESET_PC.

Verification
REQ-033 Reset, enable=1, memory acks after 2 cycles with data 0xA5 -> mem_addr=0x00, ir=0xA5, ir_pc=0x00, ir_valid=1, pc=0x01.
REQ-034 Sequential fetch with ir_ready=1, 256+ instructions (ADDR_W=8) -> ir_pc sequence 0x00..0xFF then 0x00 (wrap).
REQ-035 ir_ready=0 for 5 cycles with ir_valid=1 -> mem_req stays 0, ir stable, pc unchanged.
REQ-036 branch_valid to 0x40 while FETCH at 0x03, ack 3 cycles later -> ack data discarded, ir_valid=0, next mem_addr=0x40.
REQ-037 branch to 0x80 in same cycle as mem_ack -> data discarded, next request to 0x80, ir_valid remains 0.
REQ-038 reset pulsed while mem_req=1 -> mem_req drops immediately, next request to RESET_PC.
